// File: rtl/unidade_controle_if.sv
// unidade_controle_if: instruction-memory and ALU bus between the control unit and its datapath
interface unidade_controle_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack;
    logic [15:0]     imem_dado;
    logic [7:0]      ula_a;
    logic [7:0]      ula_b;
    logic [3:0]      ula_opcode;
    logic [3:0]      ula_endereco;
    logic            ula_enable;
    logic [7:0]      ula_resultado;

    modport master (
        output imem_addr, imem_req, ula_a, ula_b, ula_opcode, ula_endereco, ula_enable,
        input  imem_ack, imem_dado, ula_resultado
    );

    modport slave (
        input  imem_addr, imem_req, ula_a, ula_b, ula_opcode, ula_endereco, ula_enable,
        output imem_ack, imem_dado, ula_resultado
    );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle: fetch/decode/execute/writeback control unit with an 8-bit register bank
module unidade_controle #(
    parameter int PC_W  = 8,
    parameter int N_REG = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    unidade_controle_if.master  bus,
    output logic                ocupado,
    output logic                parado,
    output logic                erro_div,
    input  logic [3:0]          dbg_sel,
    output logic [7:0]          dbg_dado
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [7:0]      regs_q [N_REG];
    logic [7:0]      regs_d [N_REG];
    logic [7:0]      ula_a_q, ula_a_d, ula_b_q, ula_b_d;
    logic [3:0]      opcode_q, opcode_d, endereco_q, endereco_d;
    logic            erro_q, erro_d;

    logic [3:0]      opc, rd, ra, rb;
    logic [7:0]      val_a, val_b;

    assign opc   = ir_q[15:12];
    assign rd    = ir_q[11:8];
    assign ra    = ir_q[7:4];
    assign rb    = ir_q[3:0];
    assign val_a = (32'(ra) < N_REG) ? regs_q[ra] : 8'h00;
    assign val_b = (32'(rb) < N_REG) ? regs_q[rb] : 8'h00;

    assign bus.imem_addr    = pc_q;
    assign bus.imem_req     = state_q == FETCH;
    assign bus.ula_a        = ula_a_q;
    assign bus.ula_b        = ula_b_q;
    assign bus.ula_opcode   = opcode_q;
    assign bus.ula_endereco = endereco_q;
    assign bus.ula_enable   = state_q == EXEC;
    assign ocupado          = state_q inside {FETCH, DECODE, EXEC, WB};
    assign parado           = state_q == HALT;
    assign erro_div         = erro_q;
    assign dbg_dado         = (32'(dbg_sel) < N_REG) ? regs_q[dbg_sel] : 8'h00;

    // Next state: operands are captured in DECODE so rd==rA/rB sees pre-instruction values
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        regs_d     = regs_q;
        ula_a_d    = ula_a_q;
        ula_b_d    = ula_b_q;
        opcode_d   = opcode_q;
        endereco_d = endereco_q;
        erro_d     = erro_q;
        case (state_q)
            IDLE: state_d = start ? FETCH : IDLE;
            FETCH: if (bus.imem_ack) begin
                ir_d    = bus.imem_dado;
                pc_d    = pc_q + PC_W'(1);
                state_d = DECODE;
            end
            DECODE: begin
                if (opc == 4'd15) begin
                    state_d = HALT;
                end else if (opc == 4'd14) begin
                    pc_d    = PC_W'(ir_q[7:0]);
                    state_d = FETCH;
                end else if (opc == 4'd13) begin
                    if (32'(rd) < N_REG) regs_d[rd] = ir_q[7:0];
                    state_d = FETCH;
                end else if (opc == 4'd4 && val_b == 8'h00) begin
                    erro_d  = 1'b1;
                    state_d = HALT;
                end else begin
                    ula_a_d    = val_a;
                    ula_b_d    = val_b;
                    opcode_d   = opc;
                    endereco_d = rd;
                    state_d    = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                if (opc != 4'd12 && 32'(rd) < N_REG) regs_d[rd] = bus.ula_resultado;
                state_d = FETCH;
            end
            default: state_d = state_q;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            ula_a_q    <= '0;
            ula_b_q    <= '0;
            opcode_q   <= '0;
            endereco_q <= '0;
            erro_q     <= 1'b0;
            for (int i = 0; i < N_REG; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ula_a_q    <= ula_a_d;
            ula_b_q    <= ula_b_d;
            opcode_q   <= opcode_d;
            endereco_q <= endereco_d;
            erro_q     <= erro_d;
            regs_q     <= regs_d;
        end
    end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: randomized and directed programs checked against an instruction-level model
module tb_unidade_controle;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dbg_sel = 4'h0;
    logic [7:0] dbg_dado;
    logic       ocupado, parado, erro_div;

    unidade_controle_if #(.PC_W(8)) ifc ();

    unidade_controle #(.PC_W(8), .N_REG(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bus      (ifc.master),
        .ocupado  (ocupado),
        .parado   (parado),
        .erro_div (erro_div),
        .dbg_sel  (dbg_sel),
        .dbg_dado (dbg_dado)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem [256];
    logic [7:0]  exp_fetch [$];
    logic [23:0] exp_exec [$];
    int          fetch_cyc [$];
    int          cyc = 0;
    int          en_cnt = 0;
    int          acks_left = 0;
    int          fixed_delay = 0;
    bit          sb_on = 0;
    logic [7:0]  m_reg [16];
    bit          m_halt, m_err;
    logic [7:0]  m_pc;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return 8'(a * b);
            4'd4:    return (b != 0) ? a / b : 8'h00;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            default: return a + b + {4'h0, op};
        endcase
    endfunction

    always_comb ifc.ula_resultado = alu_f(ifc.ula_opcode, ifc.ula_a, ifc.ula_b);

    function automatic int pick();
        return (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Instruction memory: acks after a chosen delay while fetching; stray acks with noise otherwise
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        ifc.imem_ack  = 1'b0;
        ifc.imem_dado = 16'h0;
        forever begin
            @(negedge clock);
            if (ifc.imem_req && reset) begin
                if (wait_cnt == 0 && acks_left > 0) begin
                    ifc.imem_ack  = 1'b1;
                    ifc.imem_dado = mem[ifc.imem_addr];
                    acks_left--;
                end else begin
                    ifc.imem_ack  = 1'b0;
                    ifc.imem_dado = 16'($urandom);
                    if (wait_cnt > 0) wait_cnt--;
                end
            end else begin
                ifc.imem_ack  = ($urandom_range(0, 3) == 0);
                ifc.imem_dado = 16'($urandom);
                wait_cnt      = pick();
            end
        end
    end

    // Monitor: pops expected fetches/ALU issues and checks fetch-request stability
    initial begin
        logic       prev_req, prev_ack;
        logic [7:0] prev_addr;
        logic [7:0] ef;
        logic [23:0] ee;
        prev_req = 0; prev_ack = 0; prev_addr = 0;
        forever begin
            @(negedge clock);
            #2;
            cyc++;
            if (!reset) begin
                prev_req = 0;
            end else begin
                if (sb_on && ifc.imem_req && ifc.imem_ack) begin
                    if (exp_fetch.size() == 0) chk("fetch_extra", {56'h0, ifc.imem_addr}, 64'hFFFF);
                    else begin
                        ef = exp_fetch.pop_front();
                        chk("fetch_addr", ifc.imem_addr, ef);
                        fetch_cyc.push_back(cyc);
                    end
                end
                if (ifc.imem_req && prev_req && !prev_ack) chk("req_stable", ifc.imem_addr, prev_addr);
                prev_req  = ifc.imem_req;
                prev_ack  = ifc.imem_ack;
                prev_addr = ifc.imem_addr;
                if (ifc.ula_enable) begin
                    en_cnt++;
                    if (sb_on) begin
                        if (exp_exec.size() == 0) chk("exec_extra", {ifc.ula_opcode, ifc.ula_endereco, ifc.ula_a, ifc.ula_b}, 64'hFFFFFFFF);
                        else begin
                            ee = exp_exec.pop_front();
                            chk("exec_bus", {ifc.ula_opcode, ifc.ula_endereco, ifc.ula_a, ifc.ula_b}, ee);
                        end
                    end
                end
            end
        end
    end

    task automatic model_run(input int max_steps);
        int          pc, n;
        bit          done;
        logic [15:0] ir;
        logic [3:0]  op, rd, ra, rb;
        exp_fetch.delete();
        exp_exec.delete();
        for (int r = 0; r < 16; r++) m_reg[r] = 8'h00;
        pc = 0; n = 0; done = 0; m_err = 0;
        while (!done && n < max_steps) begin
            exp_fetch.push_back(8'(pc));
            ir = mem[pc];
            pc = (pc + 1) % 256;
            n++;
            op = ir[15:12]; rd = ir[11:8]; ra = ir[7:4]; rb = ir[3:0];
            if (op == 15) done = 1;
            else if (op == 14) pc = int'(ir[7:0]);
            else if (op == 13) m_reg[rd] = ir[7:0];
            else if (op == 4 && m_reg[rb] == 0) begin m_err = 1; done = 1; end
            else begin
                exp_exec.push_back({op, rd, m_reg[ra], m_reg[rb]});
                if (op < 12) m_reg[rd] = alu_f(op, m_reg[ra], m_reg[rb]);
            end
        end
        m_halt = done;
        m_pc = 8'(pc);
        acks_left = n;
    endtask

    task automatic run_prog(input int max_steps, input int dly);
        int budget;
        fixed_delay = dly;
        model_run(max_steps);
        en_cnt = 0;
        fetch_cyc.delete();
        sb_on = 1;
        @(negedge clock);
        start = 1'b1;
        budget = 0;
        while (budget < 4000) begin
            @(negedge clock);
            start = 1'($urandom_range(0, 1));
            budget++;
            if (m_halt ? parado : (exp_fetch.size() == 0 && exp_exec.size() == 0)) break;
        end
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("parado", parado, m_halt);
        chk("ocupado", ocupado, !m_halt);
        chk("erro_div", erro_div, m_err);
        chk("fetch_left", exp_fetch.size(), 0);
        chk("exec_left", exp_exec.size(), 0);
        if (!m_halt) chk("stuck_addr", ifc.imem_addr, m_pc);
        for (int r = 0; r < 16; r++) begin
            dbg_sel = 4'(r);
            #1;
            chk($sformatf("reg%0d", r), dbg_dado, m_reg[r]);
        end
    endtask

    task automatic do_reset();
        sb_on = 0;
        @(negedge clock);
        #3;
        dbg_sel = 4'($urandom);
        reset = 1'b0;
        #1;
        chk("reset_outs", {ifc.imem_req, ifc.imem_addr, ifc.ula_a, ifc.ula_b, ifc.ula_opcode,
                           ifc.ula_endereco, ifc.ula_enable, ocupado, parado, erro_div}, 64'h0);
        chk("reset_dbg", dbg_dado, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic gen_prog();
        int         len, k;
        logic [3:0] rd, ra, rb;
        clear_mem();
        len = $urandom_range(3, 20);
        for (int i = 0; i < len - 1; i++) begin
            k  = $urandom_range(0, 9);
            rd = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom);
            if (k < 4)       mem[i] = {4'hD, rd, 8'($urandom)};
            else if (k < 8)  mem[i] = {4'($urandom_range(0, 12)), rd, ra, rb};
            else if (k == 8) mem[i] = {8'hE0, 8'($urandom_range(i + 1, len - 1))};
            else             mem[i] = {4'h4, rd, ra, rb};
        end
        mem[len - 1] = {4'hF, 12'($urandom)};
    endtask

    task automatic load_add();
        clear_mem();
        mem[0] = 16'hD105; mem[1] = 16'hD203; mem[2] = 16'h1312; mem[3] = 16'hF000;
    endtask

    initial begin
        bit seen;
        do_reset();

        load_add();
        run_prog(100, 0);
        chk("add_en_cycles", en_cnt, 1);
        chk("add_fetches", fetch_cyc.size(), 4);
        if (fetch_cyc.size() == 4) begin
            chk("ldi_cycles", fetch_cyc[1] - fetch_cyc[0], 2);
            chk("add_cycles", fetch_cyc[3] - fetch_cyc[2], 4);
        end

        do_reset();
        clear_mem();
        mem[0] = 16'hD107; mem[1] = 16'h4412; mem[2] = 16'hF000;
        run_prog(100, 0);
        chk("div0_en_cycles", en_cnt, 0);

        do_reset();
        load_add();
        run_prog(100, 3);
        if (fetch_cyc.size() == 4) chk("add_cycles_dly3", fetch_cyc[3] - fetch_cyc[2], 7);
        else chk("add_fetches_dly3", fetch_cyc.size(), 4);

        do_reset();
        clear_mem();
        mem[0] = 16'hE010; mem[16] = 16'hE0FF; mem[255] = 16'hD1AB;
        run_prog(4, 0);

        do_reset();
        clear_mem();
        mem[0] = 16'hDA2A; mem[1] = 16'hC5A0; mem[2] = 16'hF000;
        run_prog(100, 1);

        do_reset();
        load_add();
        fixed_delay = 0;
        acks_left = 1000;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            seen = ifc.ula_enable;
        end
        chk("exec_seen", seen, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_outs", {ifc.imem_req, ifc.imem_addr, ifc.ula_a, ifc.ula_b, ifc.ula_opcode,
                           ifc.ula_endereco, ifc.ula_enable, ocupado, parado, erro_div}, 64'h0);
        dbg_sel = 4'd3;
        #1;
        chk("abort_reg3", dbg_dado, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("abort_idle", {ocupado, ifc.imem_req, parado}, 3'b000);
        run_prog(100, 0);

        for (int t = 0; t < 25; t++) begin
            do_reset();
            gen_prog();
            run_prog(200, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have parameter N_REG, default 16, number of 8-bit registers in the bank.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin execution from IDLE.
REQ-006 SHALL have port imem_addr  output  PC_W  instruction address (current PC).
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port imem_ack  input  1  fetch complete; imem_dado valid this cycle.
REQ-009 SHALL have port imem_dado  input  16  instruction word: [15:12] opcode, [11:8] rd/endereco, [7:4] rA, [3:0] rB.
REQ-010 SHALL have ports ula_a, ula_b  output  8  ALU operands.
REQ-011 SHALL have ports ula_opcode  output  4, ula_endereco  output  4  ALU operation and store address.
REQ-012 SHALL have port ula_enable  output  1  ALU enable.
REQ-013 SHALL have port ula_resultado  input  8  ALU result (saidaULA).
REQ-014 SHALL have ports ocupado, parado, erro_div  output  1 each  busy, halted, divide-by-zero flags.
REQ-015 SHALL have ports dbg_sel  input  4, dbg_dado  output  8  combinational register-bank read for test.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-017 IDLE: start=1 -> FETCH; start is ignored in every other state.
REQ-018 FETCH: imem_req=1 and imem_addr=pc held stable until imem_ack; on the ack cycle, latch imem_dado into IR, pc <= pc+1 mod 2^PC_W, -> DECODE.
REQ-019 imem_ack outside FETCH SHALL be ignored; no timeout; FETCH waits indefinitely.
REQ-020 DECODE, opcodes 0..12: ula_a <= reg[rA], ula_b <= reg[rB], ula_opcode <= IR[15:12], ula_endereco <= IR[11:8], -> EXEC.
REQ-021 DECODE, opcode 4 with reg[rB]==0: erro_div <= 1, -> HALT; the ALU is not enabled.
REQ-022 DECODE, opcode 13 (LDI): reg[IR[11:8]] <= IR[7:0], -> FETCH; the ALU is not used.
REQ-023 DECODE, opcode 14 (JMP): pc <= IR[7:0] zero-extended to PC_W, -> FETCH.
REQ-024 DECODE, opcode 15 (HLT): -> HALT.
REQ-025 EXEC: ula_enable=1 for exactly this one cycle, -> WB.
REQ-026 WB: ula_a, ula_b, ula_opcode, ula_endereco held unchanged from DECODE; for opcodes 0..11 reg[IR[11:8]] <= ula_resultado sampled at the rising edge ending WB; for opcode 12 (store) no register write; -> FETCH.
REQ-027 Cycle count per instruction SHALL be: ALU op = fetch cycles + 3; LDI/JMP = fetch cycles + 1; with ack in the first FETCH cycle, an ALU op takes 4 cycles.
REQ-028 ula_enable SHALL be 0 in every state except EXEC.
REQ-029 ocupado SHALL be 1 in FETCH, DECODE, EXEC, WB; 0 in IDLE and HALT.
REQ-030 HALT: parado=1; sticky; exits only by reset.
REQ-031 Arithmetic on pc wraps modulo 2^PC_W; register data is 8-bit with no saturation.
REQ-032 rd == rA or rd == rB SHALL use the pre-instruction value as the operand, then write the result.
REQ-033 dbg_dado = reg[dbg_sel] combinationally at all times, including during reset.

Reset
REQ-034 reset=0 SHALL immediately, regardless of clock or state, force: state IDLE, pc=0, IR=0, all registers 0, ula_a=ula_b=0, ula_opcode=0, ula_endereco=0, ula_enable=0, imem_req=0, ocupado=0, parado=0, erro_div=0.
REQ-035 Reset asserted mid-fetch or mid-EXEC SHALL abort the instruction with no register write; on release the block waits in IDLE for start.

Verification
REQ-036 Program LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 (0x1312); HLT, with ack on the first FETCH cycle -> reg3=0x08, parado=1, and the ADD takes 4 cycles with ula_enable high for 1 cycle.
REQ-037 r1=0x07, r2=0x00, DIV r4,r1,r2 (0x4412) -> erro_div=1, parado=1, ula_enable never asserted, reg4 unchanged at 0x00.
REQ-038 imem_ack delayed 3 cycles -> imem_req and imem_addr stable for all 3 wait cycles plus the ack cycle; a stray ack in IDLE has no effect.
REQ-039 JMP 0xFF at pc=0x10, then fetch at 0xFF -> the next fetch address is 0x00 (wrap).
REQ-040 Reset pulse during EXEC of ADD r3,r1,r2 -> all outputs at reset values asynchronously, reg3=0x00, state IDLE, start is required to resume from pc=0.
REQ-041 Store 0xC5A0 with r10=0x2A -> ula_opcode=0xC, ula_endereco=0x5, ula_a=0x2A during EXEC; no register changes.
